// File: rtl/workout_sequencer_pkg.sv
// Shared encodings for the interval workout sequencer.
// State values are fixed because they are exported on state_out.
package workout_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WORK   = 3'd1;
   localparam logic [2:0] ST_REST   = 3'd2;
   localparam logic [2:0] ST_RREST  = 3'd3;
   localparam logic [2:0] ST_PAUSED = 3'd4;
   localparam logic [2:0] ST_FINISH = 3'd5;

   typedef enum logic [2:0] {
      PH_IDLE   = ST_IDLE,
      PH_WORK   = ST_WORK,
      PH_REST   = ST_REST,
      PH_RREST  = ST_RREST,
      PH_PAUSED = ST_PAUSED,
      PH_FINISH = ST_FINISH
   } phase_e;

   localparam int MIN_DUR = 1;

endpackage

// File: rtl/workout_sequencer_if.sv
// Control/config inputs and registered status outputs of the workout sequencer.
// master drives the controls (tick source, buttons); slave is the sequencer.
interface workout_sequencer_if #(
   parameter int CNT_W  = 8,
   parameter int RND_W  = 4,
   parameter int TIME_W = 8
) ();

   logic              tick;
   logic              start;
   logic              pause;
   logic              skip;
   logic [CNT_W-1:0]  n_ex;
   logic [RND_W-1:0]  n_rounds;
   logic [TIME_W-1:0] work_time;
   logic [TIME_W-1:0] rest_time;
   logic [TIME_W-1:0] rrest_time;

   logic [2:0]        state_out;
   logic [TIME_W-1:0] remaining;
   logic [CNT_W-1:0]  ex_left;
   logic [RND_W-1:0]  rnd_left;
   logic              show_time;
   logic              beep_cycle_end;
   logic              beep_round_end;
   logic              beep_finish;
   logic              done;

   modport master (
      output tick, start, pause, skip, n_ex, n_rounds, work_time, rest_time, rrest_time,
      input  state_out, remaining, ex_left, rnd_left, show_time,
             beep_cycle_end, beep_round_end, beep_finish, done
   );

   modport slave (
      input  tick, start, pause, skip, n_ex, n_rounds, work_time, rest_time, rrest_time,
      output state_out, remaining, ex_left, rnd_left, show_time,
             beep_cycle_end, beep_round_end, beep_finish, done
   );

endinterface

// File: rtl/workout_sequencer_phase_timer.sv
// Per-phase countdown: load sets the duration, each unfrozen tick decrements it.
// expire is combinational: skip, or a tick while one tick remains.
module phase_timer #(
   parameter int TIME_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [TIME_W-1:0] load_val,
   input  logic              tick,
   input  logic              freeze,
   input  logic              skip,
   output logic [TIME_W-1:0] remaining,
   output logic              expire
);

   assign expire = !freeze && (skip || (tick && remaining == TIME_W'(1)));

   // The last tick never decrements; the owner reloads on expire instead.
   always_ff @(posedge clk) begin
      if (reset) begin
         remaining <= '0;
      end else if (load) begin
         remaining <= load_val;
      end else if (!freeze && tick && remaining > TIME_W'(1)) begin
         remaining <= remaining - TIME_W'(1);
      end
   end

endmodule

// File: rtl/workout_sequencer.sv
// Interval workout controller: work/rest/inter-round-rest phases, pause, skip.
// All outputs registered; start or phase expiry at edge k is visible after edge k.
module workout_sequencer
   import workout_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int RND_W  = 4,
   parameter int TIME_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   workout_sequencer_if.slave bus
);

   phase_e            state_q, state_d, ret_q, ret_d;
   logic [CNT_W-1:0]  ex_q, ex_d, n_ex_q;
   logic [RND_W-1:0]  rnd_q, rnd_d, n_rnd_q;
   logic [TIME_W-1:0] work_q, rest_q, rrest_q;
   logic [TIME_W-1:0] load_val, remaining, work_dur;
   logic              load, freeze, expire, latch, active;
   logic              cyc_d, rndb_d, fin_d, cyc_q, rndb_q, fin_q;
   logic              show_q, done_q;

   function automatic logic [TIME_W-1:0] at_least_min(input logic [TIME_W-1:0] d);
      return (d < TIME_W'(MIN_DUR)) ? TIME_W'(MIN_DUR) : d;
   endfunction

   assign active   = state_q inside {PH_WORK, PH_REST, PH_RREST};
   assign freeze   = !active || bus.pause;
   assign work_dur = at_least_min(work_q);

   phase_timer #(.TIME_W(TIME_W)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_val  (load_val),
      .tick      (bus.tick),
      .freeze    (freeze),
      .skip      (bus.skip),
      .remaining (remaining),
      .expire    (expire)
   );

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      ex_d     = ex_q;
      rnd_d    = rnd_q;
      load     = 1'b0;
      load_val = '0;
      latch    = 1'b0;
      cyc_d    = 1'b0;
      rndb_d   = 1'b0;
      fin_d    = 1'b0;
      case (state_q)
         PH_IDLE: begin
            if (bus.start) begin
               latch = 1'b1;
               load  = 1'b1;
               if (bus.n_ex == '0 || bus.n_rounds == '0) begin
                  state_d = PH_FINISH;
                  ex_d    = '0;
                  rnd_d   = '0;
               end else begin
                  state_d  = PH_WORK;
                  ex_d     = bus.n_ex;
                  rnd_d    = bus.n_rounds;
                  load_val = at_least_min(bus.work_time);
               end
            end
         end
         PH_WORK, PH_REST, PH_RREST: begin
            if (bus.pause) begin
               ret_d   = state_q;
               state_d = PH_PAUSED;
            end else if (expire) begin
               load = 1'b1;
               if (state_q != PH_WORK) begin
                  state_d  = PH_WORK;
                  load_val = work_dur;
                  cyc_d    = (state_q == PH_REST);
                  rndb_d   = (state_q == PH_RREST);
               end else if (ex_q > CNT_W'(1)) begin
                  ex_d = ex_q - CNT_W'(1);
                  // A zero-length rest collapses straight into the next work phase.
                  if (rest_q == '0) begin
                     state_d  = PH_WORK;
                     load_val = work_dur;
                     cyc_d    = 1'b1;
                  end else begin
                     state_d  = PH_REST;
                     load_val = rest_q;
                  end
               end else if (rnd_q > RND_W'(1)) begin
                  rnd_d = rnd_q - RND_W'(1);
                  ex_d  = n_ex_q;
                  if (rrest_q == '0) begin
                     state_d  = PH_WORK;
                     load_val = work_dur;
                     rndb_d   = 1'b1;
                  end else begin
                     state_d  = PH_RREST;
                     load_val = rrest_q;
                  end
               end else begin
                  state_d = PH_FINISH;
                  ex_d    = '0;
                  rnd_d   = '0;
                  fin_d   = 1'b1;
               end
            end
         end
         PH_PAUSED: begin
            if (bus.pause) state_d = ret_q;
         end
         PH_FINISH: begin
            if (bus.start) state_d = PH_IDLE;
         end
         default: begin
            state_d = PH_IDLE;
            load    = 1'b1;
            ex_d    = '0;
            rnd_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= PH_IDLE;
         ret_q   <= PH_IDLE;
         ex_q    <= '0;
         rnd_q   <= '0;
         n_ex_q  <= '0;
         n_rnd_q <= '0;
         work_q  <= '0;
         rest_q  <= '0;
         rrest_q <= '0;
         cyc_q   <= 1'b0;
         rndb_q  <= 1'b0;
         fin_q   <= 1'b0;
         show_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         ex_q    <= ex_d;
         rnd_q   <= rnd_d;
         if (latch) begin
            n_ex_q  <= bus.n_ex;
            n_rnd_q <= bus.n_rounds;
            work_q  <= bus.work_time;
            rest_q  <= bus.rest_time;
            rrest_q <= bus.rrest_time;
         end
         cyc_q  <= cyc_d;
         rndb_q <= rndb_d;
         fin_q  <= fin_d;
         show_q <= state_d inside {PH_WORK, PH_REST, PH_RREST, PH_PAUSED};
         done_q <= (state_d == PH_FINISH);
      end
   end

   assign bus.state_out      = state_q;
   assign bus.remaining      = remaining;
   assign bus.ex_left        = ex_q;
   assign bus.rnd_left       = rnd_q;
   assign bus.show_time      = show_q;
   assign bus.beep_cycle_end = cyc_q;
   assign bus.beep_round_end = rndb_q;
   assign bus.beep_finish    = fin_q;
   assign bus.done           = done_q;

endmodule

// File: tb/tb_workout_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed transitions, a negedge monitor
// pops one entry per state change / beep (or per explicit snapshot request).
module tb_workout_sequencer;

   localparam int CNT_W  = 4;
   localparam int RND_W  = 4;
   localparam int TIME_W = 8;

   localparam int I = 0, W = 1, R = 2, RR = 3, P = 4, F = 5;
   localparam int CYC = 4, RB = 2, FIN = 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   workout_sequencer_if #(.CNT_W(CNT_W), .RND_W(RND_W), .TIME_W(TIME_W)) bus ();

   workout_sequencer #(.CNT_W(CNT_W), .RND_W(RND_W), .TIME_W(TIME_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string name;
      int    st;
      int    rem;
      int    ex;
      int    rnd;
      int    bp;
      int    tk;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         tick_cnt = 0;
   int         snap_req = 0;
   bit         mon_en = 1'b0;
   bit         end_req = 1'b0;

   function automatic void expect_ev(string nm, int st, int rem, int ex, int rnd, int bp, int tk);
      exp_q.push_back('{nm, st, rem, ex, rnd, bp, tk});
   endfunction

   task automatic take(input string kind);
      exp_t       e;
      logic [2:0] bp;
      bit         bad;
      checks++;
      bp = {bus.beep_cycle_end, bus.beep_round_end, bus.beep_finish};
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got st=%0d rem=%0d ex=%0d rnd=%0d beeps=%b, required no output change",
                  kind, bus.state_out, bus.remaining, bus.ex_left, bus.rnd_left, bp);
         return;
      end
      e = exp_q.pop_front();
      bad = (bus.state_out !== 3'(e.st)) || (bus.remaining !== 8'(e.rem)) ||
            (bus.ex_left !== 4'(e.ex)) || (bus.rnd_left !== 4'(e.rnd)) || (bp !== 3'(e.bp)) ||
            (bus.done !== (e.st == F)) || (bus.show_time !== (e.st inside {W, R, RR, P})) ||
            (e.tk >= 0 && tick_cnt != e.tk);
      if (bad) begin
         errors++;
         $display("FAIL %s: got st=%0d rem=%0d ex=%0d rnd=%0d beeps=%b done=%b show=%b ticks=%0d; required st=%0d rem=%0d ex=%0d rnd=%0d beeps=%b ticks=%0d",
                  e.name, bus.state_out, bus.remaining, bus.ex_left, bus.rnd_left, bp, bus.done,
                  bus.show_time, tick_cnt, e.st, e.rem, e.ex, e.rnd, 3'(e.bp), e.tk);
      end
   endtask

   initial begin : monitor
      logic [2:0] prev_st;
      int         snap_seen;
      bit         ev;
      prev_st   = 3'd0;
      snap_seen = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            ev = (bus.state_out !== prev_st) || (bus.beep_cycle_end === 1'b1) ||
                 (bus.beep_round_end === 1'b1) || (bus.beep_finish === 1'b1);
            if (ev) take("event");
            if (snap_req != snap_seen) begin
               snap_seen = snap_req;
               take("snapshot");
            end
            if (end_req) begin
               checks++;
               if (exp_q.size() != 0) begin
                  errors++;
                  $display("FAIL leftover_expectations: got %0d pending, required 0", exp_q.size());
               end
               $display("CHECKS %0d ERRORS %0d", checks, errors);
               $finish;
            end
         end
         prev_st = bus.state_out;
      end
   end

   task automatic step(input bit t, input bit s, input bit p, input bit k, input bit r);
      bus.tick  = t;
      bus.start = s;
      bus.pause = p;
      bus.skip  = k;
      reset     = r;
      @(posedge clk);
      if (t) tick_cnt++;
      #1;
      bus.tick  = 1'b0;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.skip  = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic set_cfg(input int ne, input int nr, input int w, input int r, input int rr);
      bus.n_ex       = 4'(ne);
      bus.n_rounds   = 4'(nr);
      bus.work_time  = 8'(w);
      bus.rest_time  = 8'(r);
      bus.rrest_time = 8'(rr);
   endtask

   task automatic begin_session();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick_cnt = 0;
   endtask

   task automatic end_session(input string nm);
      expect_ev(nm, I, 0, 0, 0, 0, -1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin : stimulus
      bus.tick  = 1'b0;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.skip  = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      expect_ev("reset_state", I, 0, 0, 0, 0, -1);
      snap_req++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);

      // Basic run: 3 exercises, 1 round, work 3, rest 2
      set_cfg(3, 1, 3, 2, 7);
      expect_ev("t1_work1", W, 3, 3, 1, 0, 0);
      begin_session();
      expect_ev("t1_rest1",  R, 2, 2, 1, 0,   3);
      expect_ev("t1_work2",  W, 3, 2, 1, CYC, 5);
      expect_ev("t1_rest2",  R, 2, 1, 1, 0,   8);
      expect_ev("t1_work3",  W, 3, 1, 1, CYC, 10);
      expect_ev("t1_finish", F, 0, 0, 0, FIN, 13);
      ticks(13);
      idle(2);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      end_session("t1_idle");
      idle(1);

      // Multi-round with config changed after start
      set_cfg(2, 2, 2, 1, 4);
      expect_ev("t2_work1", W, 2, 2, 2, 0, 0);
      begin_session();
      set_cfg(9, 9, 7, 7, 0);
      expect_ev("t2_rest1",  R,  1, 1, 2, 0,   2);
      expect_ev("t2_work2",  W,  2, 1, 2, CYC, 3);
      expect_ev("t2_rrest",  RR, 4, 2, 1, 0,   5);
      expect_ev("t2_work3",  W,  2, 2, 1, RB,  9);
      expect_ev("t2_rest2",  R,  1, 1, 1, 0,   11);
      expect_ev("t2_work4",  W,  2, 1, 1, CYC, 12);
      expect_ev("t2_finish", F,  0, 0, 0, FIN, 14);
      ticks(14);
      idle(1);
      end_session("t2_idle");

      // Pause/resume, ignored tick/skip/start while paused, pause priority
      set_cfg(1, 1, 8, 0, 0);
      expect_ev("t3_work", W, 8, 1, 1, 0, 0);
      begin_session();
      ticks(3);
      expect_ev("t3_pause", P, 5, 1, 1, 0, 3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(10);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_ev("t3_frozen", P, 5, 1, 1, 0, 13);
      snap_req++;
      expect_ev("t3_resume", W, 5, 1, 1, 0, 13);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_ev("t3_pause_tick", P, 5, 1, 1, 0, 14);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_ev("t3_resume2", W, 5, 1, 1, 0, 14);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_ev("t3_pause_skip", P, 5, 1, 1, 0, 14);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      expect_ev("t3_resume3", W, 5, 1, 1, 0, 14);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_ev("t3_finish", F, 0, 0, 0, FIN, 19);
      ticks(5);
      idle(1);
      end_session("t3_idle");

      // skip+tick at remaining 1 in REST: one transition only; start ignored in WORK
      set_cfg(2, 1, 2, 3, 0);
      expect_ev("t4_work1", W, 2, 2, 1, 0, 0);
      begin_session();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_ev("t4_rest", R, 3, 1, 1, 0, 2);
      ticks(4);
      expect_ev("t4_skip_tick", W, 2, 1, 1, CYC, 5);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      expect_ev("t4_skip_work", F, 0, 0, 0, FIN, 5);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      end_session("t4_idle");

      // Zero exercise / zero round counts finish immediately without a beep
      set_cfg(0, 3, 5, 5, 5);
      expect_ev("t5_zero_ex", F, 0, 0, 0, 0, 0);
      begin_session();
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end_session("t5_idle1");
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      set_cfg(3, 0, 5, 5, 5);
      expect_ev("t5_zero_rnd", F, 0, 0, 0, 0, 0);
      begin_session();
      end_session("t5_idle2");

      // work 0 acts as 1; zero rests bypass REST and RREST
      set_cfg(2, 2, 0, 0, 0);
      expect_ev("t6_work1", W, 1, 2, 2, 0, 0);
      begin_session();
      expect_ev("t6_work2",  W, 1, 1, 2, CYC, 1);
      expect_ev("t6_work3",  W, 1, 2, 1, RB,  2);
      expect_ev("t6_work4",  W, 1, 1, 1, CYC, 3);
      expect_ev("t6_finish", F, 0, 0, 0, FIN, 4);
      ticks(4);
      idle(2);
      end_session("t6_idle");

      // Full-scale exercise count on a 4-bit counter
      set_cfg(15, 1, 1, 0, 3);
      expect_ev("t7_work1", W, 1, 15, 1, 0, 0);
      begin_session();
      for (int i = 1; i <= 14; i++) expect_ev($sformatf("t7_work_%0d", i + 1), W, 1, 15 - i, 1, CYC, i);
      expect_ev("t7_finish", F, 0, 0, 0, FIN, 15);
      ticks(15);
      idle(1);
      end_session("t7_idle");

      // Reset mid-REST on an expiring tick: IDLE, no beep, then a clean session
      set_cfg(2, 1, 1, 3, 0);
      expect_ev("t8_work", W, 1, 2, 1, 0, 0);
      begin_session();
      expect_ev("t8_rest", R, 3, 1, 1, 0, 1);
      ticks(3);
      expect_ev("t8_reset", I, 0, 0, 0, 0, -1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_ev("t8_after_reset", I, 0, 0, 0, 0, -1);
      snap_req++;
      idle(2);
      set_cfg(1, 1, 2, 0, 0);
      expect_ev("t8_clean_work", W, 2, 1, 1, 0, 0);
      begin_session();
      expect_ev("t8_clean_finish", F, 0, 0, 0, FIN, 2);
      ticks(2);
      idle(1);
      end_session("t8_idle");
      idle(2);

      end_req = 1'b1;
      repeat (5) @(posedge clk);
      $display("FAIL monitor_timeout: got no summary, required summary within 5 cycles");
      $fatal(1, "monitor did not terminate");
   end

endmodule
